mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 155 +++++++++++++++
 tb/tb_mul_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of one shared sequential multiplier: grants, holds operands
// for MUL_LAT cycles, then captures the product. Define MUL_ARB_RR_EN for round-robin arbitration.
module mul_arbiter #(
    parameter int MUL_LAT = 8,
    parameter int W       = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0,
    input  logic           req1,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic [2*W-1:0] result,
    output logic           mul_en,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_c,
    output logic           busy
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_owner;
    logic             w_owner_nxt;
    logic             w_sel;
    logic             w_start;
    logic             w_capture;
    logic [W-1:0]     r_mul_a;
    logic [W-1:0]     r_mul_b;
    logic [2*W-1:0]   r_result;

`ifdef MUL_ARB_RR_EN
    logic             r_last;

    // Reset value 1 makes requester 0 the first winner of a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_start) begin
            r_last <= w_sel;
        end
    end

    always_comb begin
        w_sel = 1'b0;
        if (req0 && req1) begin
            w_sel = ~r_last;
        end else begin
            w_sel = req1;
        end
    end
`else
    // A tie always goes to requester 0.
    always_comb begin
        w_sel = 1'b0;
        if (!req0) begin
            w_sel = req1;
        end
    end
`endif

    // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_start     = 1'b1;
                    w_owner_nxt = w_sel;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_capture   = 1'b1;
                    w_state_nxt = CAPT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            CAPT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // NOTE: datapath registers are reset too, so mul_a/mul_b/result read 0 after any reset, even mid-run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_result <= '0;
        end else begin
            if (w_start) begin
                r_mul_a <= w_sel ? a1 : a0;
                r_mul_b <= w_sel ? b1 : b0;
            end
            if (w_capture) begin
                r_result <= mul_c;
            end
        end
    end

    // Outputs decode straight from registered state, so reset clears them immediately.
    assign mul_en = (r_state == RUN);
    assign busy   = (r_state != IDLE);
    assign gnt0   = (r_state == RUN) && (r_cnt == '0) && !r_owner;
    assign gnt1   = (r_state == RUN) && (r_cnt == '0) &&  r_owner;
    assign done0  = (r_state == CAPT) && !r_owner;
    assign done1  = (r_state == CAPT) &&  r_owner;
    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    assign result = r_result;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: vector table plus hand-written multi-cycle sequences.
// Expected values follow MUL_ARB_RR_EN when that macro is defined for the build.
module tb_mul_arbiter;

    localparam int MUL_LAT = 8;
    localparam int W       = 8;
`ifdef MUL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1, done0, done1;
    logic [2*W-1:0] result;
    logic           mul_en;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_c;
    logic           busy;

    int total = 0;
    int bad   = 0;

    mul_arbiter #(.MUL_LAT(MUL_LAT), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequential multiplier model: the product is only valid in the last enabled cycle.
    int             k;
    logic [2*W-1:0] prod;
    always @(posedge clk) begin
        if (!mul_en) k <= 0;
        else         k <= k + 1;
    end
    assign prod  = {8'h00, mul_a} * {8'h00, mul_b};
    assign mul_c = (mul_en && k == MUL_LAT - 1) ? prod : 16'hBEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r0;
        logic        r1;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [7:0]  a1;
        logic [7:0]  b1;
        logic        own;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[5];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n_en;
        int n_g;
        @(negedge clk);
        req0 = v.r0; req1 = v.r1;
        a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
        @(negedge clk);
        check({tag, "_gnt0"}, gnt0, !v.own);
        check({tag, "_gnt1"}, gnt1, v.own);
        check({tag, "_mul_a"}, mul_a, v.own ? v.a1 : v.a0);
        check({tag, "_mul_b"}, mul_b, v.own ? v.b1 : v.b0);
        req0 = 1'b0; req1 = 1'b0;
        n_en = 0; n_g = 0;
        while (mul_en && n_en < 50) begin
            n_en++;
            n_g += int'(gnt0) + int'(gnt1);
            @(negedge clk);
        end
        check({tag, "_run_len"}, n_en, MUL_LAT);
        check({tag, "_gnt_pulses"}, n_g, 1);
        check({tag, "_done0"}, done0, !v.own);
        check({tag, "_done1"}, done1, v.own);
        check({tag, "_result"}, result, v.res);
        @(negedge clk);
        check({tag, "_done_clear"}, done0 | done1, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_mul_en", mul_en, 0);
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_result", result, 0);
        check("rst_mul_ab", {mul_a, mul_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // r0 r1  a0   b0   a1   b1   owner result
        vecs[0] = '{1'b1, 1'b0, 8'd239, 8'd35,  8'd0,   8'd0,   1'b0, 16'd8365};
        vecs[1] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd255, 8'd255, 1'b1, 16'd65025};
        vecs[2] = '{1'b1, 1'b1, 8'd0,   8'd200, 8'd7,   8'd9,   1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 8'd3,   8'd4,   8'd100, 8'd200, RR,   RR ? 16'd20000 : 16'd12};
        vecs[4] = '{1'b1, 1'b0, 8'd255, 8'd255, 8'd0,   8'd0,   1'b0, 16'd65025};
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Both requesters held continuously from a fresh reset.
        begin
            int cyc, ng, nd, g1;
            int gt[4];
            logic go[4];
            logic [15:0] rs[4];
            do_reset();
            @(negedge clk);
            req0 = 1'b1; req1 = 1'b1;
            a0 = 8'd255; b0 = 8'd255; a1 = 8'd3; b1 = 8'd4;
            cyc = 0; ng = 0; nd = 0; g1 = 0;
            while (nd < 4 && cyc < 80) begin
                @(negedge clk);
                cyc++;
                if (gnt1) g1++;
                if ((gnt0 || gnt1) && ng < 4) begin
                    gt[ng] = cyc; go[ng] = gnt1; ng++;
                end
                if ((done0 || done1) && nd < 4) begin
                    rs[nd] = result; nd++;
                end
            end
            req0 = 1'b0; req1 = 1'b0;
            check("b2b_grants", ng, 4);
            check("b2b_dones", nd, 4);
            check("b2b_gnt1_count", g1, RR ? 2 : 0);
            for (int i = 0; i < 4; i++) begin
                if (i < ng) check($sformatf("b2b_owner%0d", i), go[i], RR ? (i % 2) : 0);
                if (i < nd) check($sformatf("b2b_result%0d", i), rs[i],
                                  (RR && (i % 2 == 1)) ? 12 : 65025);
                if (i > 0 && i < ng) check($sformatf("b2b_spacing%0d", i), gt[i] - gt[i-1], MUL_LAT + 2);
            end
            repeat (3) @(negedge clk);
            check("b2b_idle", busy, 0);
        end

        // req1 raised while requester 0 is running: ignored until IDLE.
        begin
            int cyc, t_d0, t_g1, low, gap;
            logic [15:0] r_d0, r_d1;
            @(negedge clk);
            req0 = 1'b1; a0 = 8'd12; b0 = 8'd11;
            @(negedge clk);
            check("late_gnt0", gnt0, 1);
            req0 = 1'b0;
            cyc = 0; t_d0 = -1; t_g1 = -1; low = 0; gap = -1; r_d0 = '0; r_d1 = '0;
            while (cyc < 40 && r_d1 == '0) begin
                if (cyc == 2) begin
                    req1 = 1'b1; a1 = 8'd5; b1 = 8'd6;
                end
                if (!mul_en) begin
                    low++;
                end else begin
                    if (low > 0 && gap < 0) gap = low;
                    low = 0;
                end
                if (done0 && t_d0 < 0) begin t_d0 = cyc; r_d0 = result; end
                if (gnt1 && t_g1 < 0) begin t_g1 = cyc; req1 = 1'b0; end
                if (done1) r_d1 = result;
                @(negedge clk);
                cyc++;
            end
            check("late_result0", r_d0, 132);
            check("late_result1", r_d1, 30);
            check("late_gnt1_delay", t_g1 - t_d0, 2);
            check("late_en_gap", gap, 2);
        end

        // Reset in the 4th RUN cycle aborts the transaction.
        begin
            int n_done;
            @(negedge clk);
            req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
            @(negedge clk);
            req0 = 1'b0;
            repeat (3) @(negedge clk);
            check("abort_running", mul_en, 1);
            rst_n = 1'b0;
            #1;
            check("abort_mul_en", mul_en, 0);
            check("abort_busy", busy, 0);
            check("abort_result", result, 0);
            check("abort_mul_a", mul_a, 0);
            n_done = 0;
            repeat (3) begin
                @(negedge clk);
                n_done += int'(done0) + int'(done1);
            end
            rst_n = 1'b1;
            for (int i = 0; i < MUL_LAT + 2; i++) begin
                @(negedge clk);
                n_done += int'(done0) + int'(done1);
            end
            check("abort_no_done", n_done, 0);
            check("abort_result_hold", result, 0);
            run_vec('{1'b1, 1'b0, 8'd17, 8'd3, 8'd0, 8'd0, 1'b0, 16'd51}, "post_rst");
        end

        // req0 dropped before the edge that would grant it.
        begin
            int n_g, n_en;
            @(negedge clk);
            req0 = 1'b1; a0 = 8'd1; b0 = 8'd1;
            #2;
            req0 = 1'b0;
            n_g = 0; n_en = 0;
            repeat (12) begin
                @(negedge clk);
                n_g  += int'(gnt0) + int'(gnt1);
                n_en += int'(mul_en);
            end
            check("drop_no_gnt", n_g, 0);
            check("drop_no_mul_en", n_en, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
